// File: rtl/extr_template_seq.sv
// Template sequencer: walks the extraction template memory from a base entry,
// decodes each word and issues byte-pick commands over a valid/ready handshake
// until END, an illegal opcode, the entry limit, or the 54-byte budget stops it.
module extr_template_seq #(
  parameter int TMPL_AW     = 6,
  parameter int MAX_ENTRIES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TMPL_AW-1:0] tmpl_base,
  output logic               tmpl_rd_en,
  output logic [TMPL_AW-1:0] tmpl_rd_addr,
  input  logic [63:0]        tmpl_rd_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [8:0]         cmd_offset,
  output logic [7:0]         cmd_mask,
  output logic [23:0]        cmd_flip,
  output logic               busy,
  output logic               done,
  output logic [5:0]         done_bcnt,
  output logic               done_err
);

  localparam int                CNT_W     = $clog2(MAX_ENTRIES + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_ENTRIES);
  localparam logic [6:0]        MAX_BCNT  = 7'd54;

  localparam logic [1:0] OP_END  = 2'b00;
  localparam logic [1:0] OP_XDAT = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_CMD,
    S_DONE
  } state_t;

  // Number of enabled bytes in a byte-enable mask (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, m[i]};
    end
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [TMPL_AW-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         bcnt_q, bcnt_d;
  logic [8:0]         off_q, off_d;
  logic [7:0]         mask_q, mask_d;
  logic [23:0]        flip_q, flip_d;
  logic [3:0]         pc_q, pc_d;
  logic               err_q, err_d;
  logic [5:0]         dbcnt_q, dbcnt_d;
  logic               advance;

  // Decoded fields of the template word returned in the EVAL cycle.
  logic [1:0]  ev_op;
  logic [8:0]  ev_off;
  logic [7:0]  ev_mask;
  logic [23:0] ev_flip;
  logic [3:0]  ev_pc;
  logic [6:0]  ev_sum;
  logic        unused_rsvd;

  assign ev_op       = tmpl_rd_data[1:0];
  assign ev_off      = tmpl_rd_data[10:2];
  assign ev_mask     = tmpl_rd_data[18:11];
  assign ev_flip     = tmpl_rd_data[42:19];
  assign ev_pc       = popcount8(ev_mask);
  assign ev_sum      = bcnt_q + {3'b000, ev_pc};
  assign unused_rsvd = ^tmpl_rd_data[63:43];

  // Next-state and next-register values; the advance step is shared by the
  // empty-mask skip in EVAL and the command accept in CMD.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    off_d   = off_q;
    mask_d  = mask_q;
    flip_d  = flip_q;
    pc_d    = pc_q;
    err_d   = err_q;
    dbcnt_d = dbcnt_q;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = tmpl_base;
          bcnt_d  = 7'd0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (ev_op == OP_END) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (ev_op != OP_XDAT) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (ev_mask == 8'd0) begin
          advance = 1'b1;
        end else if (ev_sum > MAX_BCNT) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          off_d   = ev_off;
          mask_d  = ev_mask;
          flip_d  = ev_flip;
          pc_d    = ev_pc;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cmd_ready) begin
          bcnt_d  = bcnt_q + {3'b000, pc_q};
          advance = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      cnt_d   = cnt_q + CNT_W'(1);
      addr_d  = addr_q + TMPL_AW'(1);
      state_d = (cnt_d == CNT_LIMIT) ? S_DONE : S_FETCH;
    end

    // Capture the final byte count on entry to DONE so it holds afterwards.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      dbcnt_d = bcnt_d[5:0];
    end
  end

  // State and datapath registers; reset clears everything so all outputs start at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      bcnt_q  <= 7'd0;
      off_q   <= 9'd0;
      mask_q  <= 8'd0;
      flip_q  <= 24'd0;
      pc_q    <= 4'd0;
      err_q   <= 1'b0;
      dbcnt_q <= 6'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      off_q   <= off_d;
      mask_q  <= mask_d;
      flip_q  <= flip_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      dbcnt_q <= dbcnt_d;
    end
  end

  assign tmpl_rd_en   = (state_q == S_FETCH);
  assign tmpl_rd_addr = addr_q;
  assign cmd_valid    = (state_q == S_CMD);
  assign cmd_offset   = off_q;
  assign cmd_mask     = mask_q;
  assign cmd_flip     = flip_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign done_bcnt    = dbcnt_q;
  assign done_err     = err_q;

endmodule

// File: tb/tb_extr_template_seq.sv
// Bench for extr_template_seq: two instances (32-entry and 4-entry limits) share
// a template memory model; each walk is compared against a loop-based reference.
module tb_extr_template_seq;

  logic        clk;
  logic        rst;
  logic        start_v  [2];
  logic [5:0]  base_v   [2];
  logic        rd_en_v  [2];
  logic [5:0]  rd_addr_v[2];
  logic [63:0] rd_data_v[2];
  logic        vld_v    [2];
  logic        rdy_v    [2];
  logic [8:0]  off_v    [2];
  logic [7:0]  mask_v   [2];
  logic [23:0] flip_v   [2];
  logic        busy_v   [2];
  logic        done_v   [2];
  logic [5:0]  dbcnt_v  [2];
  logic        derr_v   [2];

  logic [63:0] mem[64];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int act = 0;
  int done_cnt[2];
  int walks[2];
  int first_rd, first_vld;
  logic [40:0] got_q[$];
  logic [5:0]  ga_q[$];
  logic [5:0]  got_bcnt;
  logic        got_err;

  logic [40:0] exp_cmd[$];
  logic [5:0]  exp_addr[$];
  int          exp_bcnt;
  logic        exp_err;
  logic        exp_first;

  extr_template_seq #(.TMPL_AW(6), .MAX_ENTRIES(32)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .tmpl_base(base_v[0]),
    .tmpl_rd_en(rd_en_v[0]), .tmpl_rd_addr(rd_addr_v[0]), .tmpl_rd_data(rd_data_v[0]),
    .cmd_valid(vld_v[0]), .cmd_ready(rdy_v[0]), .cmd_offset(off_v[0]),
    .cmd_mask(mask_v[0]), .cmd_flip(flip_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .done_bcnt(dbcnt_v[0]), .done_err(derr_v[0])
  );

  extr_template_seq #(.TMPL_AW(6), .MAX_ENTRIES(4)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .tmpl_base(base_v[1]),
    .tmpl_rd_en(rd_en_v[1]), .tmpl_rd_addr(rd_addr_v[1]), .tmpl_rd_data(rd_data_v[1]),
    .cmd_valid(vld_v[1]), .cmd_ready(rdy_v[1]), .cmd_offset(off_v[1]),
    .cmd_mask(mask_v[1]), .cmd_flip(flip_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .done_bcnt(dbcnt_v[1]), .done_err(derr_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Template memory: data returned one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en_v[0]) rd_data_v[0] <= mem[rd_addr_v[0]];
    if (rd_en_v[1]) rd_data_v[1] <= mem[rd_addr_v[1]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: records reads, accepts, done; checks hold-while-stalled.
  initial begin : monitor
    logic        pv, pr, prst;
    logic [40:0] pf;
    pv = 1'b0; pr = 1'b0; prst = 1'b1; pf = '0;
    forever begin
      @(negedge clk);
      if (done_v[0]) done_cnt[0]++;
      if (done_v[1]) done_cnt[1]++;
      if (rd_en_v[act]) begin
        ga_q.push_back(rd_addr_v[act]);
        if (first_rd < 0) first_rd = cyc;
      end
      if (vld_v[act] && first_vld < 0) first_vld = cyc;
      if (vld_v[act] && rdy_v[act]) got_q.push_back({off_v[act], mask_v[act], flip_v[act]});
      if (done_v[act]) begin
        got_bcnt = dbcnt_v[act];
        got_err  = derr_v[act];
      end
      if (pv && !pr && !prst) begin
        chk("hold_valid", 64'(vld_v[act]), 64'd1);
        chk("hold_fields", 64'({off_v[act], mask_v[act], flip_v[act]}), 64'(pf));
      end
      pv   = vld_v[act];
      pr   = rdy_v[act];
      prst = rst;
      pf   = {off_v[act], mask_v[act], flip_v[act]};
    end
  end

  function automatic logic [63:0] mk(input logic [1:0] op, input logic [8:0] off,
                                     input logic [7:0] m, input logic [23:0] fl);
    logic [20:0] rsv;
    rsv = 21'($urandom);
    return {rsv, fl, m, off, op};
  endfunction

  // Reference: walk the template with the plain termination rules.
  task automatic model(input int d, input int base);
    int maxe;
    int bytes;
    int a;
    int pc;
    logic [63:0] w;
    maxe = (d == 0) ? 32 : 4;
    bytes = 0;
    exp_cmd.delete();
    exp_addr.delete();
    exp_err = 1'b0;
    exp_first = 1'b0;
    for (int i = 0; i < maxe; i++) begin
      a = (base + i) % 64;
      w = mem[a];
      exp_addr.push_back(6'(a));
      if (w[1:0] == 2'b00) begin exp_err = 1'b0; break; end
      if (w[1]) begin exp_err = 1'b1; break; end
      pc = $countones(w[18:11]);
      if (pc == 0) continue;
      if (bytes + pc > 54) begin exp_err = 1'b1; break; end
      if (i == 0) exp_first = 1'b1;
      exp_cmd.push_back({w[10:2], w[18:11], w[42:19]});
      bytes += pc;
    end
    exp_bcnt = bytes;
  endtask

  // One full walk: rmode 0=ready high, 1=random ready, 2=ready low 5 cycles per command.
  task automatic run_walk(input int d, input int base, input int rmode, input bit extra);
    int  scyc;
    int  dc;
    int  lowc;
    bit  fin;
    model(d, base);
    act = d;
    got_q.delete();
    ga_q.delete();
    first_rd = -1;
    first_vld = -1;
    dc = done_cnt[d];
    lowc = 0;
    fin = 0;
    @(posedge clk); #1;
    base_v[d]  = 6'(base);
    start_v[d] = 1'b1;
    rdy_v[d]   = (rmode == 1) ? 1'($urandom_range(0, 1)) : (rmode == 0);
    scyc = cyc;
    for (int k = 1; k < 3000; k++) begin
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      if (extra && (k == 2 || done_v[d])) start_v[d] = 1'b1;
      if (rmode == 0) rdy_v[d] = 1'b1;
      else if (rmode == 1) rdy_v[d] = 1'($urandom_range(0, 1));
      else begin
        if (vld_v[d]) begin
          if (lowc >= 5) begin rdy_v[d] = 1'b1; lowc = 0; end
          else begin rdy_v[d] = 1'b0; lowc++; end
        end else rdy_v[d] = 1'b0;
      end
      if (done_cnt[d] != dc) begin fin = 1; break; end
    end
    chk("walk_timeout", 64'(fin), 64'd1);
    start_v[d] = 1'b0;
    rdy_v[d] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    walks[d]++;
    chk("done_once", 64'(done_cnt[d] - dc), 64'd1);
    chk("busy_after", 64'(busy_v[d]), 64'd0);
    chk("n_cmd", 64'(got_q.size()), 64'(exp_cmd.size()));
    for (int i = 0; i < got_q.size() && i < exp_cmd.size(); i++)
      chk("cmd_fields", 64'(got_q[i]), 64'(exp_cmd[i]));
    chk("n_read", 64'(ga_q.size()), 64'(exp_addr.size()));
    for (int i = 0; i < ga_q.size() && i < exp_addr.size(); i++)
      chk("rd_addr", 64'(ga_q[i]), 64'(exp_addr[i]));
    chk("done_bcnt", 64'(got_bcnt), 64'(exp_bcnt));
    chk("done_err", 64'(got_err), 64'(exp_err));
    chk("bcnt_held", 64'(dbcnt_v[d]), 64'(exp_bcnt));
    chk("lat_rd_en", 64'(first_rd), 64'(scyc + 1));
    if (exp_first) chk("lat_cmd_valid", 64'(first_vld), 64'(scyc + 3));
  endtask

  initial begin : stim
    bit seen;
    int dc;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; base_v[d] = 6'd0; rdy_v[d] = 1'b0;
      rd_data_v[d] = 64'd0; done_cnt[d] = 0; walks[d] = 0;
    end
    first_rd = -1; first_vld = -1;
    for (int i = 0; i < 64; i++) mem[i] = mk(2'b00, 9'd0, 8'd0, 24'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_cmd_valid", 64'(vld_v[d]), 64'd0);
      chk("rst_busy", 64'(busy_v[d]), 64'd0);
      chk("rst_done", 64'(done_v[d]), 64'd0);
      chk("rst_rd_en", 64'(rd_en_v[d]), 64'd0);
      chk("rst_rd_addr", 64'(rd_addr_v[d]), 64'd0);
      chk("rst_done_bcnt", 64'(dbcnt_v[d]), 64'd0);
      chk("rst_done_err", 64'(derr_v[d]), 64'd0);
      chk("rst_cmd_fields", 64'({off_v[d], mask_v[d], flip_v[d]}), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic two-command walk, 4+8 bytes.
    mem[0] = mk(2'b01, 9'd3, 8'h0F, 24'hA5A5A5);
    mem[1] = mk(2'b01, 9'd5, 8'hFF, 24'h123456);
    mem[2] = mk(2'b00, 9'd0, 8'h00, 24'd0);
    run_walk(0, 0, 0, 0);
    chk("t1_bcnt_const", 64'(got_bcnt), 64'd12);

    // Budget overflow on the seventh full-mask entry.
    for (int i = 0; i < 7; i++) mem[10 + i] = mk(2'b01, 9'(i), 8'hFF, 24'($urandom));
    mem[17] = mk(2'b00, 9'd0, 8'd0, 24'd0);
    run_walk(0, 10, 1, 0);
    chk("t2_bcnt_const", 64'(got_bcnt), 64'd48);
    chk("t2_err_const", 64'(got_err), 64'd1);

    // Exactly 54 bytes is legal.
    for (int i = 0; i < 6; i++) mem[20 + i] = mk(2'b01, 9'(100 + i), 8'hFF, 24'($urandom));
    mem[26] = mk(2'b01, 9'd200, 8'h3F, 24'($urandom));
    mem[27] = mk(2'b00, 9'd0, 8'd0, 24'd0);
    run_walk(0, 20, 0, 0);
    chk("t2b_bcnt_const", 64'(got_bcnt), 64'd54);

    // Back-pressure: ready held low 5 cycles per command.
    run_walk(0, 0, 2, 0);

    // Address wrap and 4-entry limit.
    mem[62] = mk(2'b01, 9'd1, 8'h01, 24'($urandom));
    mem[63] = mk(2'b01, 9'd2, 8'h01, 24'($urandom));
    mem[0]  = mk(2'b01, 9'd3, 8'h01, 24'($urandom));
    mem[1]  = mk(2'b01, 9'd4, 8'h01, 24'($urandom));
    run_walk(1, 62, 1, 0);
    chk("t4_bcnt_const", 64'(got_bcnt), 64'd4);

    // Empty mask skipped, then illegal opcode; extra start pulses dropped.
    mem[30] = mk(2'b01, 9'd9, 8'h00, 24'($urandom));
    mem[31] = mk(2'b11, 9'd9, 8'hFF, 24'($urandom));
    run_walk(0, 30, 0, 1);
    chk("t5_err_const", 64'(got_err), 64'd1);

    // Reset while a command is pending.
    mem[0] = mk(2'b01, 9'd7, 8'h3C, 24'hBEEF01);
    mem[1] = mk(2'b00, 9'd0, 8'd0, 24'd0);
    act = 0;
    dc = done_cnt[0];
    seen = 0;
    @(posedge clk); #1;
    base_v[0] = 6'd0; start_v[0] = 1'b1; rdy_v[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      if (vld_v[0]) begin seen = 1; break; end
    end
    chk("t6_reached_cmd", 64'(seen), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_valid_drop", 64'(vld_v[0]), 64'd0);
    chk("t6_busy_drop", 64'(busy_v[0]), 64'd0);
    chk("t6_no_done", 64'(done_v[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("t6_no_done_pulse", 64'(done_cnt[0] - dc), 64'd0);
    run_walk(0, 0, 1, 0);
    chk("t6_bcnt_const", 64'(got_bcnt), 64'd4);

    // Randomized templates, bases, instances and ready patterns.
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 64; i++) begin
        int r;
        logic [1:0] op;
        logic [7:0] m;
        r  = int'($urandom_range(0, 19));
        op = (r == 0) ? 2'b00 : (r == 1) ? 2'(2 + $urandom_range(0, 1)) : 2'b01;
        m  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        mem[i] = mk(op, 9'($urandom), m, 24'($urandom));
      end
      run_walk(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 1)), 0);
    end

    chk("done_total0", 64'(done_cnt[0]), 64'(walks[0]));
    chk("done_total1", 64'(done_cnt[1]), 64'(walks[1]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
